pipelined_rca: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into WIDTH/STAGE_BITS ripple slices, one slice per pipeline stage, carrying the carry between stages in registers.
- Accepts one operand pair per cycle with valid/ready flow control on both sides.
- Used wherever wide adds must meet timing that a single WIDTH-bit ripple chain cannot.

---
 rtl/pipelined_rca.sv | 108 ++++++++++
 tb/tb_pipelined_rca.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - pipelined ripple-carry adder, one STAGE_BITS slice per stage
// Operands enter whole; each stage consumes its low slice and forwards the rest upward.
module pipelined_rca #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_STAGES = WIDTH / STAGE_BITS;
  localparam int LAST       = NUM_STAGES - 1;

  // the whole pipeline advances in lockstep; no bubble collapsing
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : stg
    localparam int IW = WIDTH - k * STAGE_BITS;
    localparam int SW = (k + 1) * STAGE_BITS;

    logic [IW-1:0]         a_in;
    logic [IW-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [STAGE_BITS:0]   part;
    logic [SW-1:0]         sum_next;
    logic [SW-1:0]         sum_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : head
      assign a_in     = a;
      assign b_in     = b;
      assign c_in     = cin;
      assign v_in     = in_valid;
      assign sum_next = part[STAGE_BITS-1:0];
    end else begin : body
      assign a_in     = stg[k-1].fwd.a_q;
      assign b_in     = stg[k-1].fwd.b_q;
      assign c_in     = stg[k-1].c_q;
      assign v_in     = stg[k-1].v_q;
      assign sum_next = {part[STAGE_BITS-1:0], stg[k-1].sum_q};
    end

    assign part = {1'b0, a_in[STAGE_BITS-1:0]} + {1'b0, b_in[STAGE_BITS-1:0]}
                + {{STAGE_BITS{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_next;
        c_q   <= part[STAGE_BITS];
        v_q   <= v_in;
      end
    end

    if (k < LAST) begin : fwd
      // operand bits not yet summed, skewed one stage further
      logic [IW-STAGE_BITS-1:0] a_q;
      logic [IW-STAGE_BITS-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:STAGE_BITS];
          b_q <= b_in[IW-1:STAGE_BITS];
        end
      end
    end else begin : tail
      // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum
      logic c_msb;
      logic ovf_q;

      assign c_msb = part[STAGE_BITS-1] ^ a_in[STAGE_BITS-1] ^ b_in[STAGE_BITS-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb ^ part[STAGE_BITS];
        end
      end
    end
  end

  assign out_valid = stg[LAST].v_q;
  assign s         = stg[LAST].sum_q;
  assign cout      = stg[LAST].c_q;
  assign ovf       = stg[LAST].tail.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - scoreboard bench for pipelined_rca (4-stage and 1-stage builds)
module tb_pipelined_rca;

  logic clk = 1'b0;
  logic rst;

  logic        iv0, ir0, c0, ov0, or0, co0, of0;
  logic [15:0] a0, b0, s0;
  logic        iv1, ir1, c1, ov1, or1, co1, of1;
  logic [15:0] a1, b1, s1;

  pipelined_rca #(.WIDTH(16), .STAGE_BITS(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(c0),
    .out_valid(ov0), .out_ready(or0), .s(s0), .cout(co0), .ovf(of0)
  );

  pipelined_rca #(.WIDTH(16), .STAGE_BITS(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .cout(co1), .ovf(of1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] e0, e1;
  logic [18:0] hv0, hv1;
  logic        st0 = 1'b0, st1 = 1'b0;
  int          run0 = 0, best0 = 0, pops0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {cout, ovf, s}; overflow from operand/result signs
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'b0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {t[16], v, t[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      st0 = 1'b0;
      st1 = 1'b0;
      run0 = 0;
    end else begin
      check("rdy0", ir0, !ov0 || or0);
      if (st0) check("stall_hold0", {ov0, co0, of0, s0}, hv0);
      st0 = ov0 && !or0;
      hv0 = {ov0, co0, of0, s0};
      run0 = ov0 ? run0 + 1 : 0;
      if (run0 > best0) best0 = run0;
      if (ov0 && or0) begin
        check("sb0_nonempty", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("sum0", {co0, of0, s0}, e0);
          pops0++;
        end
      end
      if (iv0 && ir0) q0.push_back(model(a0, b0, c0));

      check("rdy1", ir1, !ov1 || or1);
      if (st1) check("stall_hold1", {ov1, co1, of1, s1}, hv1);
      st1 = ov1 && !or1;
      hv1 = {ov1, co1, of1, s1};
      if (ov1 && or1) begin
        check("sb1_nonempty", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("sum1", {co1, of1, s1}, e1);
        end
      end
      if (iv1 && ir1) q1.push_back(model(a1, b1, c1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // called and returning at posedge+1; holds the pair until accepted
  task automatic send0(input logic [15:0] x, input logic [15:0] y, input logic c);
    iv0 = 1'b1; a0 = x; b0 = y; c0 = c;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir0) begin
        cyc();
        iv0 = 1'b0;
        return;
      end
      cyc();
    end
    check("send0_timeout", ir0, 1);
    iv0 = 1'b0;
  endtask

  // pipeline empty behind the pair and out_ready=1: result must show on the 4th cycle exactly
  task automatic lat0(input string tag, input logic [17:0] expv);
    check({tag, "_ov_c1"}, ov0, 0);
    cyc();
    check({tag, "_ov_c2"}, ov0, 0);
    cyc();
    check({tag, "_ov_c3"}, ov0, 0);
    cyc();
    check({tag, "_ov_c4"}, ov0, 1);
    check({tag, "_val"}, {co0, of0, s0}, expv);
  endtask

  task automatic drain0();
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0 && !ov0) break;
      cyc();
    end
    check("drain0", q0.size(), 0);
  endtask

  task automatic drain1();
    for (int i = 0; i < 60; i++) begin
      if (q1.size() == 0 && !ov1) break;
      cyc();
    end
    check("drain1", q1.size(), 0);
  endtask

  logic [15:0] ba[8] = '{16'h0FFF, 16'h1234, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hAAAA, 16'h0000, 16'hFFFF};
  logic [15:0] bb[8] = '{16'h0001, 16'h4321, 16'h8000, 16'h0001, 16'h7FFF, 16'h5555, 16'h0000, 16'hFFFF};
  logic        bc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic hold0, hold1;
    int   n0, n1;

    rst = 1'b1;
    iv0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov0", ov0, 0);
    check("rst_out0", {co0, of0, s0}, 0);
    check("rst_rdy0", ir0, 1);
    check("rst_ov1", ov1, 0);
    rst = 1'b0;

    send0(16'h0006, 16'h000C, 1'b0);
    lat0("basic", 18'h00012);

    send0(16'hFFFF, 16'h0000, 1'b1);
    lat0("carry_chain", {1'b1, 1'b0, 16'h0000});
    send0(16'h7FFF, 16'h0001, 1'b0);
    lat0("sgn_ovf", {1'b0, 1'b1, 16'h8000});

    // single-stage build: result valid one cycle after acceptance
    iv1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001; c1 = 1'b0;
    @(negedge clk);
    check("s1_rdy", ir1, 1);
    cyc();
    iv1 = 1'b0;
    check("s1_lat_ov", ov1, 1);
    check("s1_lat_val", {co1, of1, s1}, {1'b1, 1'b0, 16'h0000});
    drain0();
    drain1();

    best0 = 0;
    for (int i = 0; i < 8; i++) send0(ba[i], bb[i], bc[i]);
    drain0();
    check("b2b_run", best0, 8);

    pops0 = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send0(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        repeat (4) cyc();
        or0 = 1'b0;
        repeat (5) cyc();
        or0 = 1'b1;
      end
    join
    drain0();
    check("bp_count", pops0, 6);

    for (int i = 0; i < 3; i++) send0(16'h0100 + 16'(i), 16'h0011, 1'b0);
    cyc();
    check("rst_pre_ov", ov0, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_ov", ov0, 0);
    check("rst_async_s", s0, 0);
    q0.delete();
    q1.delete();
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("no_stale", ov0, 0);
    end
    send0(16'h0001, 16'h0001, 1'b0);
    lat0("post_rst", 18'h00002);
    drain0();

    hold0 = 1'b0; hold1 = 1'b0; n0 = 0; n1 = 0;
    for (int cy = 0; cy < 60000 && (n0 < 10000 || n1 < 10000); cy++) begin
      if (!hold0) begin
        iv0 = (n0 < 10000) && ($urandom_range(0, 3) != 0);
        a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
      end
      if (!hold1) begin
        iv1 = (n1 < 10000) && ($urandom_range(0, 3) != 0);
        a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
      end
      or0 = $urandom_range(0, 3) != 0;
      or1 = $urandom_range(0, 3) != 0;
      @(negedge clk);
      hold0 = iv0 && !ir0;
      hold1 = iv1 && !ir1;
      if (iv0 && ir0) n0++;
      if (iv1 && ir1) n1++;
      cyc();
    end
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    check("rand_sent0", n0, 10000);
    check("rand_sent1", n1, 10000);
    drain0();
    drain1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
